serializer: RTL and testbench
=============================

Name: serializer

Overview:
- Parallel-to-serial converter. Captures up to 16 bits of parallel data with a valid-bit count, then shifts them out MSB-first, one bit per clock.
- Emits a per-bit valid strobe and a busy flag.
- Sits between a word-oriented producer and a bit-serial link; the producer uses busy_o for flow control.

Parameters:
- DATA_W, 16, parallel input width (power of two).
- MOD_W, 4, width of the bit-count field, equal to log2(DATA_W).

Ports:
- clk_i  input  1  system clock; all state changes on its rising edge.
- srst_i  input  1  reset, asynchronous, active-low (0 = reset).
- data_i  input  DATA_W  parallel word; bit DATA_W-1 is transmitted first.
- data_mod_i  input  MOD_W  number of valid bits counted from the MSB; 0 means all DATA_W bits.
- data_val_i  input  1  qualifies data_i/data_mod_i for one cycle.
- ser_data_o  output  1  serial data bit.
- ser_data_val_o  output  1  ser_data_o is a valid bit this cycle.
- busy_o  output  1  serializer is transmitting; input is ignored.

Behaviour:
- Reset (srst_i=0, asynchronous):
  - ser_data_o=0, ser_data_val_o=0, busy_o=0.
  - Shift register and bit counter cleared; FSM goes to IDLE.
  - Reset asserted mid-transfer aborts the transfer immediately; no further bits are emitted after release.
- Effective length N = DATA_W when data_mod_i==0, else data_mod_i.
- Acceptance: on a rising edge with srst_i=1, busy_o=0 and data_val_i=1.
  - If N>=3: latch data_i and N, then enter SEND.
  - If data_mod_i is 1 or 2: discard the word, stay IDLE, and keep all outputs low.
- data_val_i while busy_o=1 is ignored; the in-flight word is not disturbed.
- FSM has two states:
  - IDLE: outputs low; waits for acceptance.
  - SEND: each cycle presents the next bit, MSB first. Bit k (k=0..N-1) is data_i[DATA_W-1-k].
- Latency and output timing:
  - First bit appears in the cycle immediately after the accepting edge.
  - ser_data_val_o=1 and busy_o=1 for exactly N consecutive cycles.
  - On the edge after bit N-1, return to IDLE, with busy_o=0 and ser_data_val_o=0.
- Outputs are registered, and busy_o equals ser_data_val_o at all times.
- ser_data_o is 0 whenever ser_data_val_o=0.
- Back-to-back: a new word may be accepted on the first edge at which busy_o is already 0. The minimum gap between words is one idle cycle.
- Bit counter width is MOD_W+1, so it can hold N=DATA_W; no wrap-around.
- Inputs are sampled only at the accepting edge; changes to data_i afterwards have no effect.

Test Plan:
- Reset: hold srst_i=0 for several cycles, including asserting it mid-transfer -> all outputs 0 immediately and held; no bits after release until a new word is accepted.
- Full word: data_i=16'hF0F0, data_mod_i=0, one-cycle data_val_i pulse.
  - Next 16 cycles: ser_data_o = 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0.
  - ser_data_val_o=busy_o=1 throughout.
  - Cycle 17: all outputs 0.
- Partial word: data_i=16'hA000, data_mod_i=3 -> bits 1,0,1 over 3 cycles with valid/busy high, then idle.
- Invalid length: data_mod_i=1, then data_mod_i=2, each with data_val_i pulsed -> busy_o, ser_data_val_o and ser_data_o stay 0.
- Busy ignore: start 16'hFFFF, mod 0; pulse data_val_i with 16'h0000 at bit 5 -> all 16 bits are 1; the second word is dropped.
- Back-to-back: hold data_val_i=1 with 16'h8001 and mod 0 -> transfers repeat with exactly one idle cycle between them; each emits 1, fourteen 0s, 1.

Source files
------------

// File: rtl/serializer.sv
// serializer: parallel-to-serial converter.
//
// Accepts a DATA_W-bit word together with a bit count and shifts the counted bits out
// MSB-first, one per clock, starting the cycle after the accepting edge.
//
// Ports:
//   clk_i           system clock, rising edge
//   srst_i          asynchronous active-low reset
//   data_i          parallel word; bit DATA_W-1 goes out first
//   data_mod_i      number of valid bits from the MSB; 0 selects all DATA_W bits
//   data_val_i      qualifies data_i/data_mod_i; ignored while busy_o is high
//   ser_data_o      serial bit, forced low when not valid
//   ser_data_val_o  ser_data_o carries a bit this cycle
//   busy_o          transfer in progress; mirrors ser_data_val_o
module serializer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MOD_W  = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  localparam int unsigned CntW = MOD_W + 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  localparam logic [CntW-1:0] FullLen = CntW'(DATA_W);
  localparam logic [CntW-1:0] MinLen  = CntW'(3);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  // Bits still to present after the one currently on ser_data_o.
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_val_q, ser_val_d;

  logic [CntW-1:0]   len;
  logic              accept;

  always_comb begin
    len    = (data_mod_i == '0) ? FullLen : {1'b0, data_mod_i};
    // Lengths 1 and 2 are not supported by the link and are silently dropped.
    accept = (state_q == StIdle) && data_val_i && (len >= MinLen);
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    ser_data_d = 1'b0;
    ser_val_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          // First bit goes straight to the output register so it appears next cycle.
          state_d    = StSend;
          ser_data_d = data_i[DATA_W-1];
          ser_val_d  = 1'b1;
          shift_d    = data_i << 1;
          cnt_d      = len - CntW'(1);
        end
      end
      StSend: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          shift_d = '0;
        end else begin
          ser_data_d = shift_q[DATA_W-1];
          ser_val_d  = 1'b1;
          shift_d    = shift_q << 1;
          cnt_d      = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge srst_i) begin
    if (!srst_i) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ser_data_q <= ser_data_d;
      ser_val_q  <= ser_val_d;
    end
  end

  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign busy_o         = ser_val_q;

endmodule

// File: tb/tb_serializer.sv
module tb_serializer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned MOD_W  = 4;

  logic              clk_i      = 1'b0;
  logic              srst_i     = 1'b1;
  logic [DATA_W-1:0] data_i     = '0;
  logic [MOD_W-1:0]  data_mod_i = '0;
  logic              data_val_i = 1'b0;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              busy_o;

  serializer #(
    .DATA_W(DATA_W),
    .MOD_W (MOD_W)
  ) u_dut (
    .clk_i         (clk_i),
    .srst_i        (srst_i),
    .data_i        (data_i),
    .data_mod_i    (data_mod_i),
    .data_val_i    (data_val_i),
    .ser_data_o    (ser_data_o),
    .ser_data_val_o(ser_data_val_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;

  // Scoreboard: expected bits pushed at the accepting edge, popped as the DUT emits them.
  bit exp_q[$];
  int m_rem = 0;
  int m_n;
  bit m_bit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Acceptance model: tracks how many bits are still owed and loads the queue.
  always @(posedge clk_i or negedge srst_i) begin
    if (!srst_i) begin
      m_rem = 0;
      exp_q.delete();
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
    end else if (data_val_i) begin
      m_n = (data_mod_i == '0) ? DATA_W : int'(data_mod_i);
      if (m_n >= 3) begin
        m_rem = m_n;
        for (int k = 0; k < m_n; k++) exp_q.push_back(data_i[DATA_W-1-k]);
      end
    end
  end

  // Output monitor, sampled away from the active edge.
  always @(negedge clk_i) begin
    check("busy_eq_val", {31'b0, busy_o}, {31'b0, ser_data_val_o});
    check("busy", {31'b0, busy_o}, {31'b0, (m_rem != 0)});
    if (ser_data_val_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("extra_bit", 32'd1, 32'd0);
      end else begin
        m_bit = exp_q.pop_front();
        check("bit", {31'b0, ser_data_o}, {31'b0, m_bit});
      end
    end else begin
      check("idle_data", {31'b0, ser_data_o}, 32'd0);
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input logic [MOD_W-1:0] m);
    @(negedge clk_i);
    data_i     = d;
    data_mod_i = m;
    data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy_o !== 1'b0 || m_rem != 0) && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 100) check("timeout", 32'd1, 32'd0);
    check("drained", exp_q.size(), 32'd0);
    @(negedge clk_i);
  endtask

  task automatic check_outputs_low(input string tag);
    check({tag, "_data"}, {31'b0, ser_data_o}, 32'd0);
    check({tag, "_val"}, {31'b0, ser_data_val_o}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    #1 srst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_outputs_low("reset");
    srst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Full word; data_i is scrambled afterwards and must not matter.
    send(16'hF0F0, 4'd0);
    repeat (4) begin
      data_i = 16'($urandom);
      @(negedge clk_i);
    end
    wait_idle();

    // Shortest legal length.
    send(16'hA000, 4'd3);
    wait_idle();

    // Illegal lengths are dropped.
    send(16'hFFFF, 4'd1);
    send(16'hFFFF, 4'd2);
    repeat (3) @(negedge clk_i);
    check_outputs_low("drop");
    wait_idle();

    // Odd partial length.
    send(16'hB5C3, 4'd9);
    wait_idle();

    // Word offered mid-transfer is ignored.
    send(16'hFFFF, 4'd0);
    repeat (4) @(negedge clk_i);
    send(16'h0000, 4'd0);
    wait_idle();

    // Back-to-back with data_val_i held high.
    @(negedge clk_i);
    data_i     = 16'h8001;
    data_mod_i = 4'd0;
    data_val_i = 1'b1;
    repeat (52) @(negedge clk_i);
    data_val_i = 1'b0;
    wait_idle();

    // Reset in the middle of a transfer aborts it at once.
    send(16'hFFFF, 4'd0);
    repeat (3) @(negedge clk_i);
    #2 srst_i = 1'b0;
    #1 check_outputs_low("abort");
    repeat (3) @(negedge clk_i);
    check_outputs_low("abort_hold");
    srst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check_outputs_low("post_reset");

    // Recovery after abort.
    send(16'hC00F, 4'd5);
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
